// File: rtl/dma_bus_arbiter_pkg.sv
// Shared DMA definitions: arbiter FSM states, handover gap limits and
// DMA controller register addresses.
package dma_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAITAK = 3'd1,
        GRANT  = 3'd2,
        GAP    = 3'd3,
        RELCPU = 3'd4
    } arb_state_e;

    localparam int unsigned GAP_MIN = 1;
    localparam int unsigned GAP_MAX = 7;

    typedef enum logic [7:0] {
        DMA_REG_SRC_LO = 8'h00,
        DMA_REG_SRC_HI = 8'h01,
        DMA_REG_DST_LO = 8'h02,
        DMA_REG_DST_HI = 8'h03,
        DMA_REG_LEN_LO = 8'h04,
        DMA_REG_LEN_HI = 8'h05,
        DMA_REG_CTRL   = 8'h06,
        DMA_REG_STAT   = 8'h07
    } dma_reg_e;

    // Counter preload for a handover gap; out-of-range values are clamped
    // so the 3-bit counter can never be loaded with a wrapped value.
    function automatic logic [2:0] gap_load(int unsigned g);
        int unsigned c;
        c = (g < GAP_MIN) ? GAP_MIN : ((g > GAP_MAX) ? GAP_MAX : g);
        return 3'(c - 1);
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Channel/CPU/shared-bus signal bundle of the DMA bus arbiter.
// master: arbiter side (drives busak, cpu_busrq_n, dma_*); slave: environment.
interface dma_bus_arbiter_if;

    logic        busrq0_n, busrq1_n;
    logic        busak0_n, busak1_n;
    logic [15:0] a0, a1;
    logic [7:0]  dout0, dout1;
    logic        mreq0_n, iorq0_n, rd0_n, wr0_n;
    logic        mreq1_n, iorq1_n, rd1_n, wr1_n;
    logic        cpu_busrq_n, cpu_busak_n;
    logic [15:0] dma_a;
    logic [7:0]  dma_dout;
    logic        dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n;
    logic        owner, busy;

    modport master (
        input  busrq0_n, busrq1_n, a0, a1, dout0, dout1,
        input  mreq0_n, iorq0_n, rd0_n, wr0_n,
        input  mreq1_n, iorq1_n, rd1_n, wr1_n,
        input  cpu_busak_n,
        output busak0_n, busak1_n, cpu_busrq_n,
        output dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
        output owner, busy
    );

    modport slave (
        output busrq0_n, busrq1_n, a0, a1, dout0, dout1,
        output mreq0_n, iorq0_n, rd0_n, wr0_n,
        output mreq1_n, iorq1_n, rd1_n, wr1_n,
        output cpu_busak_n,
        input  busak0_n, busak1_n, cpu_busrq_n,
        input  dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
        input  owner, busy
    );

endinterface

// File: rtl/dma_bus_arbiter.sv
// Two-channel DMA bus arbiter: takes the Z80 bus via BUSRQ/BUSAK, grants it
// round-robin to DMA channels and muxes the owner onto the shared DMA bus.
// Ports: clk, rst (async, active high), bus (dma_bus_arbiter_if.master).
module dma_bus_arbiter #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic               clk,
    input logic               rst,
    dma_bus_arbiter_if.master bus
);
    import dma_bus_arbiter_pkg::*;

    localparam logic [2:0] GAP_LOAD = gap_load(GAP_CYCLES);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       cpurq_n_q, cpurq_n_d;
    logic [1:0] busak_q, busak_d;
    logic [2:0] gap_q, gap_d;

    logic [1:0] rq;
    logic       ak;
    logic       other;
    logic       strb_idle;
    logic       busy;

    assign rq    = {~bus.busrq1_n, ~bus.busrq0_n};
    assign ak    = ~bus.cpu_busak_n;
    assign other = ~owner_q;
    assign busy  = ~&busak_q;

    // Outgoing owner must have finished its last cycle before handover.
    assign strb_idle = owner_q
        ? (bus.mreq1_n & bus.iorq1_n & bus.rd1_n & bus.wr1_n)
        : (bus.mreq0_n & bus.iorq0_n & bus.rd0_n & bus.wr0_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cpurq_n_q <= 1'b1;
            busak_q   <= 2'b11;
            gap_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cpurq_n_q <= cpurq_n_d;
            busak_q   <= busak_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cpurq_n_d = cpurq_n_q;
        busak_d   = busak_q;
        gap_d     = gap_q;
        unique case (state_q)
            IDLE: begin
                if (|rq) begin
                    // Both requesting: the one not served last wins.
                    owner_d   = (&rq) ? ~last_q : rq[1];
                    cpurq_n_d = 1'b0;
                    state_d   = WAITAK;
                end
            end
            WAITAK: begin
                if (rq[owner_q]) begin
                    if (ak) begin
                        busak_d[owner_q] = 1'b0;
                        state_d          = GRANT;
                    end
                end else if (rq[other]) begin
                    owner_d = other;
                end else begin
                    cpurq_n_d = 1'b1;
                    state_d   = RELCPU;
                end
            end
            GRANT: begin
                if (!rq[owner_q]) begin
                    busak_d = 2'b11;
                    last_d  = owner_q;
                    if (rq[other]) begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        cpurq_n_d = 1'b1;
                        state_d   = RELCPU;
                    end
                end
            end
            GAP: begin
                if (gap_q != 3'd0) begin
                    gap_d = gap_q - 3'd1;
                end else if (!rq[other]) begin
                    cpurq_n_d = 1'b1;
                    state_d   = RELCPU;
                end else if (strb_idle) begin
                    owner_d        = other;
                    busak_d[other] = 1'b0;
                    state_d        = GRANT;
                end
            end
            RELCPU: begin
                if (!ak) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busak0_n    = busak_q[0];
    assign bus.busak1_n    = busak_q[1];
    assign bus.cpu_busrq_n = cpurq_n_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy;

    assign bus.dma_a      = !busy ? 16'h0000 : (owner_q ? bus.a1 : bus.a0);
    assign bus.dma_dout   = !busy ? 8'hFF : (owner_q ? bus.dout1 : bus.dout0);
    assign bus.dma_mreq_n = !busy | (owner_q ? bus.mreq1_n : bus.mreq0_n);
    assign bus.dma_iorq_n = !busy | (owner_q ? bus.iorq1_n : bus.iorq0_n);
    assign bus.dma_rd_n   = !busy | (owner_q ? bus.rd1_n : bus.rd0_n);
    assign bus.dma_wr_n   = !busy | (owner_q ? bus.wr1_n : bus.wr0_n);

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: vector table, handover/reset sequences and
// random traffic against a reference model, on GAP_CYCLES=1 and =4.
module tb_dma_bus_arbiter;

    typedef struct packed {
        logic        b0, b1, crq, own, busy;
        logic [15:0] a;
        logic [7:0]  d;
        logic [3:0]  st;
    } obs_t;

    typedef struct packed {
        logic rq0_n, rq1_n, ak_n;
        logic b0, b1, crq, own, busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq0_n, rq1_n, ak_n;
    logic [15:0] a0, a1;
    logic [7:0]  d0, d1;
    logic [3:0]  st0, st1;
    obs_t        obs [2];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        dma_bus_arbiter_if bi ();
        assign bi.busrq0_n    = rq0_n;
        assign bi.busrq1_n    = rq1_n;
        assign bi.cpu_busak_n = ak_n;
        assign bi.a0          = a0;
        assign bi.a1          = a1;
        assign bi.dout0       = d0;
        assign bi.dout1       = d1;
        assign {bi.mreq0_n, bi.iorq0_n, bi.rd0_n, bi.wr0_n} = st0;
        assign {bi.mreq1_n, bi.iorq1_n, bi.rd1_n, bi.wr1_n} = st1;
        assign obs[k] = {bi.busak0_n, bi.busak1_n, bi.cpu_busrq_n,
                         bi.owner, bi.busy, bi.dma_a, bi.dma_dout,
                         bi.dma_mreq_n, bi.dma_iorq_n, bi.dma_rd_n,
                         bi.dma_wr_n};
        dma_bus_arbiter #(.GAP_CYCLES(k == 0 ? 1 : 4)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bi)
        );
    end

    // Reference model: who holds the bus, whether the CPU bus is requested,
    // and which phase (waiting / gap countdown / releasing) is in progress.
    int m_own [2], m_last [2], m_grant [2], m_gap [2];
    bit m_crq [2], m_wait [2], m_rel [2];
    int gapn [2] = '{1, 4};

    function automatic obs_t mk(logic b0, logic b1, logic crq, logic own,
                                logic busy);
        obs_t o;
        o.b0 = b0; o.b1 = b1; o.crq = crq; o.own = own; o.busy = busy;
        o.a = 16'h0000; o.d = 8'hFF; o.st = 4'hF;
        if (busy) begin
            if (own) begin o.a = a1; o.d = d1; o.st = st1; end
            else begin o.a = a0; o.d = d0; o.st = st0; end
        end
        return o;
    endfunction

    function automatic void check(string nm, int k, obs_t act, obs_t exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got b0=%b b1=%b crq=%b own=%b busy=%b a=%h d=%h st=%b, expected b0=%b b1=%b crq=%b own=%b busy=%b a=%h d=%h st=%b",
                nm, k, act.b0, act.b1, act.crq, act.own, act.busy, act.a,
                act.d, act.st, exp.b0, exp.b1, exp.crq, exp.own, exp.busy,
                exp.a, exp.d, exp.st);
        end
    endfunction

    function automatic void check_int(string nm, int k, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", nm, k, act, exp);
        end
    endfunction

    function automatic void mreset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_last[k] = 1; m_grant[k] = -1; m_gap[k] = 0;
            m_crq[k] = 0; m_wait[k] = 0; m_rel[k] = 0;
        end
    endfunction

    function automatic void mstep(int k);
        bit r [2];
        bit sidle [2];
        bit ack;
        int o;
        r[0] = !rq0_n; r[1] = !rq1_n; ack = !ak_n;
        sidle[0] = &st0; sidle[1] = &st1;
        if (m_rel[k]) begin
            if (!ack) m_rel[k] = 0;
        end else if (m_grant[k] >= 0) begin
            if (!r[m_grant[k]]) begin
                m_last[k] = m_grant[k];
                o = 1 - m_grant[k];
                m_grant[k] = -1;
                if (r[o]) m_gap[k] = gapn[k];
                else begin m_crq[k] = 0; m_rel[k] = 1; end
            end
        end else if (m_gap[k] > 0) begin
            o = 1 - m_own[k];
            if (m_gap[k] > 1) m_gap[k]--;
            else if (!r[o]) begin
                m_gap[k] = 0; m_crq[k] = 0; m_rel[k] = 1;
            end else if (sidle[m_own[k]]) begin
                m_gap[k] = 0; m_own[k] = o; m_grant[k] = o;
            end
        end else if (m_wait[k]) begin
            o = 1 - m_own[k];
            if (r[m_own[k]]) begin
                if (ack) begin m_grant[k] = m_own[k]; m_wait[k] = 0; end
            end else if (r[o]) m_own[k] = o;
            else begin m_wait[k] = 0; m_crq[k] = 0; m_rel[k] = 1; end
        end else if (r[0] || r[1]) begin
            m_own[k] = (r[0] && r[1]) ? 1 - m_last[k] : (r[0] ? 0 : 1);
            m_crq[k] = 1;
            m_wait[k] = 1;
        end
    endfunction

    function automatic obs_t mexp(int k);
        return mk(m_grant[k] != 0, m_grant[k] != 1, !m_crq[k],
                  m_own[k] == 1, m_grant[k] >= 0);
    endfunction

    initial begin
        vec_t tbl [14];
        int   cnt [2];
        bit   done [2];
        int   gown [2];
        bit   got;
        int   cur, oth;

        tbl = '{
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}
        };

        rst = 1'b1; rq0_n = 1'b1; rq1_n = 1'b1; ak_n = 1'b1;
        a0 = 16'h8000; a1 = 16'h1234; d0 = 8'h5A; d1 = 8'hA5;
        st0 = 4'b0110; st1 = 4'b1001;
        #1;
        for (int k = 0; k < 2; k++) check("reset", k, obs[k], mk(1, 1, 1, 0, 0));
        @(negedge clk); rst = 1'b0;

        // Single request, withdraw in WAITAK, idle bus with live strobes.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rq0_n = tbl[i].rq0_n; rq1_n = tbl[i].rq1_n; ak_n = tbl[i].ak_n;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                check($sformatf("vec%0d", i), k, obs[k],
                      mk(tbl[i].b0, tbl[i].b1, tbl[i].crq, tbl[i].own,
                         tbl[i].busy));
        end

        // Simultaneous requests from reset, then alternating handovers.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        st0 = 4'hF; st1 = 4'hF; rq0_n = 1'b0; rq1_n = 1'b0; ak_n = 1'b1;
        repeat (2) @(negedge clk);
        ak_n = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            got = !obs[0].b0 || !obs[0].b1 || !obs[1].b0 || !obs[1].b1;
        end
        for (int k = 0; k < 2; k++) check("first_grant", k, obs[k], mk(0, 1, 0, 0, 1));

        for (int r = 0; r < 4; r++) begin
            cur = r % 2; oth = 1 - cur;
            @(negedge clk);
            if (cur == 0) rq0_n = 1'b1; else rq1_n = 1'b1;
            for (int k = 0; k < 2; k++) begin cnt[k] = 0; done[k] = 0; gown[k] = -1; end
            for (int c = 0; c < 20 && !(done[0] && done[1]); c++) begin
                @(posedge clk); #1;
                for (int k = 0; k < 2; k++) begin
                    if (!done[k]) begin
                        if ((oth == 0) ? !obs[k].b0 : !obs[k].b1) begin
                            done[k] = 1; gown[k] = int'(obs[k].own);
                        end else if (obs[k].b0 && obs[k].b1 && !obs[k].crq) begin
                            cnt[k]++;
                        end
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                check_int($sformatf("gap_cycles_r%0d", r), k, cnt[k], gapn[k]);
                check_int($sformatf("next_owner_r%0d", r), k, gown[k], oth);
            end
            @(negedge clk);
            if (cur == 0) rq0_n = 1'b0; else rq1_n = 1'b0;
        end

        // Asynchronous reset while channel 0 holds the bus.
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("pre_rst", k, obs[k], mk(0, 1, 0, 0, 1));
        #2; rst = 1'b1; #1;
        for (int k = 0; k < 2; k++) check("rst_in_grant", k, obs[k], mk(1, 1, 1, 0, 0));

        // Random traffic against the model.
        rq0_n = 1'b1; rq1_n = 1'b1; ak_n = 1'b1;
        @(negedge clk); rst = 1'b0;
        mreset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) rq0_n = ~rq0_n;
            if ($urandom_range(7) == 0) rq1_n = ~rq1_n;
            if ($urandom_range(3) == 0) ak_n = ~ak_n;
            st0 = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            st1 = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            a0 = 16'($urandom); a1 = 16'($urandom);
            d0 = 8'($urandom);  d1 = 8'($urandom);
            @(posedge clk);
            mstep(0); mstep(1);
            #1;
            for (int k = 0; k < 2; k++) check("rand", k, obs[k], mexp(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 1, idle cycles inserted between release by one owner and grant to the next (legal 1..7).
REQ-002 clk  in  1  system clock; the only clock, all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 busrq0_n, busrq1_n  in  1 each  bus request from DMA channel 0 / channel 1, active low.
REQ-005 busak0_n, busak1_n  out  1 each  per-channel bus acknowledge, active low.
REQ-006 a0, a1  in  16 each; dout0, dout1  in  8 each  channel address and write data.
REQ-007 mreq0_n, iorq0_n, rd0_n, wr0_n, mreq1_n, iorq1_n, rd1_n, wr1_n  in  1 each  channel strobes, active low.
REQ-008 cpu_busrq_n  out  1  request to Z80 BUSRQ; cpu_busak_n  in  1  Z80 BUSAK.
REQ-009 dma_a  out  16; dma_dout  out  8; dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n  out  1 each  shared DMA bus.
REQ-010 owner  out  1  index of current/last granted channel; busy  out  1  high while any channel holds busak.

Function
REQ-011 FSM states SHALL be: IDLE, WAITAK, GRANT, GAP, RELCPU.
REQ-012 IDLE: when either busrq*_n is low, the FSM SHALL select a winner, register it in owner, drive cpu_busrq_n low and enter WAITAK next cycle.
REQ-013 Winner when both request: the channel other than last_served (round-robin); when one requests: that channel.
REQ-014 WAITAK: when cpu_busak_n is low and the winner still requests, the FSM SHALL enter GRANT and drive busak<owner>_n low in that same registered update.
REQ-015 WAITAK: when the winner withdraws, the FSM SHALL re-arbitrate to the other channel if it requests, else drive cpu_busrq_n high and enter RELCPU.
REQ-016 GRANT: busak<owner>_n SHALL stay low while busrq<owner>_n stays low; the non-owner busak SHALL always be high; no preemption.
REQ-017 GRANT: on busrq<owner>_n high, the FSM SHALL drive busak<owner>_n high, set last_served to owner, and enter GAP if the other channel requests, else drive cpu_busrq_n high and enter RELCPU.
REQ-018 GAP: cpu_busrq_n SHALL stay low (CPU bus retained); after GAP_CYCLES cycles, provided all owner strobes are high, owner SHALL switch and the FSM SHALL enter GRANT with the new busak low; if the other channel withdrew meanwhile, enter RELCPU with cpu_busrq_n high.
REQ-019 RELCPU: FSM SHALL wait for cpu_busak_n high, then enter IDLE; new requests are not served before that.
REQ-020 Shared bus SHALL be a combinational mux selected by registered owner while busy; when not busy dma_a=0000h, dma_dout=FFh, all dma strobes high.
REQ-021 GAP counter SHALL be 3-bit, loaded with GAP_CYCLES-1 on GAP entry, decremented to zero, no wrap.
REQ-022 A busrq*_n pulse shorter than one clock SHALL not be required to be served.

Reset
REQ-023 On rst high, immediately and asynchronously: state IDLE, cpu_busrq_n=1, busak0_n=busak1_n=1, owner=0, last_served=1, gap counter 0, busy=0.
REQ-024 Reset asserted mid-GRANT SHALL release the CPU bus (cpu_busrq_n high) without waiting for channel release.

Structure
REQ-025 FSM state encodings and the GAP_CYCLES range limits SHALL live in the shared DMA package/include alongside the DMA register addresses.
REQ-026 Single module; no sub-module (two-way mux is inline).

Verification
REQ-027 Single request: busrq0_n low, cpu_busak_n low 3 cycles later -> busak0_n low one cycle later, dma_a follows a0=8000h; busrq0_n high -> busak0_n high, cpu_busrq_n high next cycle.
REQ-028 Simultaneous: both busrq low from reset -> ch0 granted first; on ch0 release, GAP_CYCLES=1 idle cycle with cpu_busrq_n low, then busak1_n low; repeat -> ch1 then ch0 order alternates.
REQ-029 Withdraw in WAITAK: busrq1_n low then high before cpu_busak_n -> cpu_busrq_n high, no busak1_n assertion, FSM in IDLE after cpu_busak_n returns high.
REQ-030 Idle bus: no owner -> dma_a=0000h, dma_dout=FFh, all strobes high regardless of channel inputs.
REQ-031 Reset in GRANT: rst pulse while busak0_n low -> busak0_n and cpu_busrq_n high within the same cycle, owner=0.
REQ-032 GAP_CYCLES=4: handover shows exactly 4 cycles with both busak high and cpu_busrq_n low.
